bcd_scan_counter: RTL and testbench

Parametrised N-digit decimal (BCD) up/down counter with an integrated time-multiplexed seven-segment driver for the PMOD display. It generalises the current fixed two-digit, count-up-only design with configurable digit count, tick and scan rates, count direction, synchronous clear, wrap indication, leading-zero blanking and segment polarity. It connects directly to the top-level segment and digit-select pins.

---
 rtl/bcd_scan_counter.sv | 167 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// Purpose : N-digit BCD up/down counter with a time-multiplexed seven-segment driver.
// Latency : bcd/wrap update one edge after the tick cycle; seg/dig_sel lag idx/count by one cycle.
// Flow    : no backpressure; en gates the prescaler, clr overrides a pending step.
//
// Ports:
//   clk      rising-edge system clock
//   rst      synchronous active-high reset
//   en       count enable (prescaler advances only while high)
//   up       direction, 1 = up, 0 = down, sampled on the tick cycle
//   clr      synchronous clear of count and prescaler
//   seg      segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dig_sel  one-hot active-high digit enable, bit 0 = least significant digit
//   bcd      current count, nibble i = digit i
//   wrap     one-cycle pulse after an all-9s -> all-0s (or reverse) step
module bcd_scan_counter #(
  parameter int DIGITS         = 2,
  parameter int TICK_DIV       = 5000000,
  parameter int SCAN_DIV       = 32768,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]            pre;
  logic [SW-1:0]            scn;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   cnt;
  logic [DIGITS-1:0][3:0]   cnt_nxt;
  logic                     at_end;
  logic                     tick;
  logic [DIGITS-1:0]        blank;
  logic [3:0]               cur_dig;
  logic                     cur_blank;

  assign tick = en && (pre == PRE_MAX);
  assign bcd  = cnt;

  // Active-high pattern for one decimal digit.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // Ripple increment/decrement. A carry (or borrow) that survives past the
  // top digit means every digit rolled over, which is exactly the wrap case.
  always_comb begin
    logic carry;
    cnt_nxt = cnt;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up) begin
          if (cnt[i] >= 4'd9) begin
            cnt_nxt[i] = 4'd0;
          end else begin
            cnt_nxt[i] = cnt[i] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (cnt[i] == 4'd0) begin
            cnt_nxt[i] = 4'd9;
          end else begin
            cnt_nxt[i] = cnt[i] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
    at_end = carry;
  end

  // Leading-zero mask: walk down from the top digit while digits stay zero.
  // Digit 0 is never part of the walk so a zero count still shows "0".
  always_comb begin
    logic lz;
    blank = '0;
    lz    = BLANK_LEADING;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz       = lz && (cnt[i] == 4'd0);
      blank[i] = lz;
    end
  end

  // Digit currently being scanned.
  always_comb begin
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_dig   = cnt[i];
        cur_blank = blank[i];
      end
    end
  end

  // Prescaler and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (en) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + PW'(1);
      end
      if (tick) begin
        cnt  <= cnt_nxt;
        wrap <= at_end;
      end
    end
  end

  // Free-running scan; deliberately ignores en and clr so the display keeps
  // refreshing while the count is frozen or cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      scn     <= '0;
      idx     <= '0;
      dig_sel <= '0;
      seg     <= SEG_OFF;
    end else begin
      if (scn == SCN_MAX) begin
        scn <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
      end else begin
        scn <= scn + SW'(1);
      end
      dig_sel <= DIGITS'(1) << idx;
      seg     <= cur_blank ? SEG_OFF : (seg_code(cur_dig) ^ {7{SEG_ACTIVE_LOW}});
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Purpose : directed self-checking bench for bcd_scan_counter (3 digits, tick/4, scan/2).
// Latency : expectations are stated per clock edge after each input change.
// Flow    : inputs driven 1 time unit after the rising edge, outputs sampled there too.
module tb_bcd_scan_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        clr;
  logic [6:0]  seg;
  logic [2:0]  dig_sel;
  logic [11:0] bcd;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  bcd_scan_counter #(
    .DIGITS         (3),
    .TICK_DIV       (4),
    .SCAN_DIV       (2),
    .SEG_ACTIVE_LOW (1'b1),
    .BLANK_LEADING  (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .seg     (seg),
    .dig_sel (dig_sel),
    .bcd     (bcd),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    int d;
    rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0;
    step();
    step();
    check("rst_bcd",     32'(bcd),     32'h000);
    check("rst_wrap",    32'(wrap),    32'h0);
    check("rst_dig_sel", 32'(dig_sel), 32'h0);
    check("rst_seg",     32'(seg),     32'h7F);

    // Count up from reset: first edge shows digit 0, first step at edge 4.
    rst = 1'b0; en = 1'b1;
    step();
    check("first_dig_sel", 32'(dig_sel), 32'h1);
    check("first_seg",     32'(seg),     32'h40);
    repeat (2) step();
    check("pre_tick_bcd", 32'(bcd), 32'h000);
    step();
    check("step1_bcd", 32'(bcd), 32'h001);
    for (int i = 2; i <= 10; i++) begin
      repeat (4) step();
      check("up_bcd", 32'(bcd), 32'(to_bcd(i)));
    end

    // Run to 999 then roll over.
    for (int i = 11; i <= 999; i++) repeat (4) step();
    check("up_999",      32'(bcd),  32'h999);
    check("up_999_wrap", 32'(wrap), 32'h0);
    repeat (4) step();
    check("wrap_up_bcd",   32'(bcd),  32'h000);
    check("wrap_up_pulse", 32'(wrap), 32'h1);
    step();
    check("wrap_up_end", 32'(wrap), 32'h0);

    // Count down from 000: pre is 1 here, so the next tick is 3 edges away.
    up = 1'b0;
    repeat (3) step();
    check("down_999",       32'(bcd),  32'h999);
    check("down_wrap_pulse",32'(wrap), 32'h1);
    step();
    check("down_wrap_end", 32'(wrap), 32'h0);
    repeat (3) step();
    check("down_998", 32'(bcd), 32'h998);
    for (int i = 997; i >= 100; i--) repeat (4) step();
    check("down_100", 32'(bcd), 32'h100);
    repeat (4) step();
    check("down_099", 32'(bcd), 32'h099);

    // clr on a tick cycle at 057.
    rst = 1'b1; step(); rst = 1'b0; up = 1'b1;
    repeat (57 * 4) step();
    check("clr_pre_057", 32'(bcd), 32'h057);
    repeat (3) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_bcd",  32'(bcd),  32'h000);
    check("clr_wrap", 32'(wrap), 32'h0);
    repeat (3) step();
    check("clr_hold", 32'(bcd), 32'h000);
    step();
    check("clr_step", 32'(bcd), 32'h001);

    // en low for 10 cycles mid-prescale (pre = 2).
    repeat (2) step();
    en = 1'b0;
    repeat (10) step();
    check("en_freeze", 32'(bcd), 32'h001);
    en = 1'b1;
    step();
    check("en_resume_wait", 32'(bcd), 32'h001);
    step();
    check("en_resume_step", 32'(bcd), 32'h002);

    // en dropped on the tick cycle blocks that step.
    repeat (3) step();
    en = 1'b0;
    step();
    check("en_tick_drop", 32'(bcd), 32'h002);
    en = 1'b1;
    step();
    check("en_tick_resume", 32'(bcd), 32'h003);

    // Scan at count 005: edge e after reset release selects digit ((e-1)/2)%3.
    rst = 1'b1; step(); rst = 1'b0; en = 1'b1;
    for (int e = 1; e <= 20; e++) step();
    en = 1'b0;
    check("scan_bcd", 32'(bcd), 32'h005);
    for (int e = 21; e <= 32; e++) begin
      step();
      d = ((e - 1) / 2) % 3;
      check("scan_dig_sel", 32'(dig_sel), 32'(1 << d));
      check("scan_seg",     32'(seg),     (d == 0) ? 32'h12 : 32'h7F);
    end

    // Count 000 still shows "0" on digit 0.
    clr = 1'b1; step(); clr = 1'b0;
    step();
    for (int k = 0; k < 8 && dig_sel != 3'b001; k++) step();
    check("zero_dig_sel", 32'(dig_sel), 32'h1);
    check("zero_seg",     32'(seg),     32'h40);

    // rst mid-operation at 123.
    en = 1'b1;
    repeat (123 * 4) step();
    check("pre_rst_123", 32'(bcd), 32'h123);
    rst = 1'b1;
    step();
    check("midrst_bcd",     32'(bcd),     32'h000);
    check("midrst_wrap",    32'(wrap),    32'h0);
    check("midrst_dig_sel", 32'(dig_sel), 32'h0);
    check("midrst_seg",     32'(seg),     32'h7F);
    rst = 1'b0;
    step();
    check("post_rst_dig_sel", 32'(dig_sel), 32'h1);
    check("post_rst_seg",     32'(seg),     32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
